// File: rtl/pipeline_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface pipeline_fetch_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_req_ack;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  modport master (output mem_req, mem_addr, input mem_req_ack, mem_resp_valid, mem_resp_data);
  modport slave  (input mem_req, mem_addr, output mem_req_ack, mem_resp_valid, mem_resp_data);
endinterface

// File: rtl/pipeline_fetch.sv
// Single-outstanding instruction fetch stage with redirect and one-response drop.
// Optional FETCH_LINE_REUSE_EN: serve the upper half of the last fetched line without a new request.
module pipeline_fetch #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   entry_pc,
  pipeline_fetch_if.master        mem,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  input  logic                    next_stage_ready,
  output logic [DATA_WIDTH/2-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]   instruction_pc
);
  localparam int IW = DATA_WIDTH / 2;
  localparam logic [IW-1:0] BUBBLE = IW'(90);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [IW-1:0]         resp_lo, resp_hi;

`ifdef FETCH_LINE_REUSE_EN
  logic                  line_vld;
  logic [ADDR_WIDTH-4:0] line_tag;
  logic [IW-1:0]         line_hi;
  logic                  reuse_hit;
  assign reuse_hit = !pc[2] && line_vld && (line_tag == pc[ADDR_WIDTH-1:3]);
`endif

  assign pc_inc       = pc + ADDR_WIDTH'(4);
  assign resp_lo      = mem.mem_resp_data[IW-1:0];
  assign resp_hi      = mem.mem_resp_data[DATA_WIDTH-1:IW];
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = {pc[ADDR_WIDTH-1:3], 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= entry_pc;
      mem_req_q      <= 1'b0;
      instruction    <= BUBBLE;
      instruction_pc <= '0;
`ifdef FETCH_LINE_REUSE_EN
      line_vld       <= 1'b0;
`endif
    end else if (redirect) begin
      pc             <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      instruction    <= BUBBLE;
      instruction_pc <= '0;
`ifdef FETCH_LINE_REUSE_EN
      line_vld       <= 1'b0;
`endif
      // A request already accepted by memory must have its response swallowed.
      unique case (state)
        WAIT:    begin state <= mem.mem_resp_valid ? REQ : DROP; mem_req_q <= mem.mem_resp_valid; end
        REQ:     begin state <= mem.mem_req_ack ? DROP : REQ;    mem_req_q <= !mem.mem_req_ack;   end
        DROP:    begin state <= mem.mem_resp_valid ? REQ : DROP; mem_req_q <= mem.mem_resp_valid; end
        default: begin state <= REQ;                             mem_req_q <= 1'b1;               end
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          state     <= REQ;
          mem_req_q <= 1'b1;
        end
        REQ: if (mem.mem_req_ack) begin
          state     <= WAIT;
          mem_req_q <= 1'b0;
        end
        WAIT: if (mem.mem_resp_valid) begin
          state          <= HOLD;
          instruction    <= pc[2] ? resp_hi : resp_lo;
          instruction_pc <= pc;
`ifdef FETCH_LINE_REUSE_EN
          line_vld       <= 1'b1;
          line_tag       <= pc[ADDR_WIDTH-1:3];
          line_hi        <= resp_hi;
`endif
        end
        DROP: if (mem.mem_resp_valid) begin
          state     <= REQ;
          mem_req_q <= 1'b1;
        end
        HOLD: if (next_stage_ready) begin
          pc <= pc_inc;
`ifdef FETCH_LINE_REUSE_EN
          if (reuse_hit) begin
            instruction    <= line_hi;
            instruction_pc <= pc_inc;
          end else begin
            state          <= REQ;
            mem_req_q      <= 1'b1;
            instruction    <= BUBBLE;
            instruction_pc <= '0;
          end
`else
          state          <= REQ;
          mem_req_q      <= 1'b1;
          instruction    <= BUBBLE;
          instruction_pc <= '0;
`endif
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
